// File: rtl/dmem_axi_master.sv
// Data-side AXI4-Lite master: turns one MEM-stage load/store into a single
// AXI4-Lite read or write transaction, stalling the pipeline until it completes.
module dmem_axi_master #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [1:0]            store_type,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           write_data,
    output logic [31:0]           read_data_axi,
    output logic                  stall,
    output logic                  bus_error,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [2:0]            m_axi_awprot,
    output logic [31:0]           m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    output logic [2:0]            m_axi_arprot,
    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wstrb;
    logic [31:0]           r_rdata;
    logic                  r_aw_done;
    logic                  r_w_done;
    logic                  r_err;

    logic                  w_req;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic [31:0]           w_lane_data;
    logic [3:0]            w_lane_strb;

    assign w_req   = mem_read | mem_write;
    assign w_aw_hs = m_axi_awvalid & m_axi_awready;
    assign w_w_hs  = m_axi_wvalid & m_axi_wready;

    // Replicate narrow store data across lanes so the strobe alone selects bytes.
    always_comb begin
        w_lane_data = write_data;
        w_lane_strb = 4'b1111;
        case (store_type)
            2'b00: begin
                w_lane_data = {4{write_data[7:0]}};
                w_lane_strb = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                w_lane_data = {2{write_data[15:0]}};
                w_lane_strb = 4'b0011 << {addr[1], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_next  = r_state;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        stall         = 1'b0;
        bus_error     = 1'b0;
        case (r_state)
            IDLE: begin
                stall = w_req;
                if (w_req) begin
                    w_state_next = mem_write ? WR_ADDR : RD_ADDR;
                end
            end
            WR_ADDR: begin
                stall         = 1'b1;
                m_axi_awvalid = ~r_aw_done;
                m_axi_wvalid  = ~r_w_done;
                if ((r_aw_done | (m_axi_awready & ~r_aw_done)) &&
                    (r_w_done | (m_axi_wready & ~r_w_done))) begin
                    w_state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                stall        = 1'b1;
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) w_state_next = DONE;
            end
            RD_ADDR: begin
                stall         = 1'b1;
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) w_state_next = RD_DATA;
            end
            RD_DATA: begin
                stall        = 1'b1;
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) w_state_next = DONE;
            end
            DONE: begin
                bus_error    = r_err;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
        // The pipeline must not freeze while the system is held in reset.
        if (!rst) stall = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_addr    <= {addr[ADDR_WIDTH-1:2], 2'b00};
                        r_wdata   <= w_lane_data;
                        r_wstrb   <= w_lane_strb;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_err     <= 1'b0;
                    end
                end
                WR_ADDR: begin
                    if (w_aw_hs) r_aw_done <= 1'b1;
                    if (w_w_hs)  r_w_done  <= 1'b1;
                end
                WR_RESP: begin
                    if (m_axi_bvalid) r_err <= (m_axi_bresp != 2'b00);
                end
                RD_DATA: begin
                    if (m_axi_rvalid) begin
                        r_rdata <= m_axi_rdata;
                        r_err   <= (m_axi_rresp != 2'b00);
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_axi_awaddr  = r_addr;
    assign m_axi_araddr  = r_addr;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_arprot  = 3'b000;
    assign read_data_axi = r_rdata;

endmodule
